// File: rtl/gpio_irq_ctrl_pkg.sv
// Register map shared by the GPIO interrupt controller and its bus decode.
package gpio_irq_ctrl_pkg;

    localparam int REG_IDX_W = 3;

    localparam logic [REG_IDX_W-1:0] REG_IRQ_EN  = 3'd0;
    localparam logic [REG_IDX_W-1:0] REG_RISE_EN = 3'd1;
    localparam logic [REG_IDX_W-1:0] REG_FALL_EN = 3'd2;
    localparam logic [REG_IDX_W-1:0] REG_PENDING = 3'd3;
    localparam logic [REG_IDX_W-1:0] REG_LEVEL   = 3'd4;

endpackage

// File: rtl/gpio_debounce.sv
// Single-pin two-flop synchroniser followed by a counter-based debouncer.
module gpio_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            // Any sample agreeing with the accepted level restarts the run.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpio_irq_ctrl.sv
// Per-pin debounced edge interrupts with enable/pending registers on the peripheral bus.
module gpio_irq_ctrl
    import gpio_irq_ctrl_pkg::*;
#(
    parameter int WIDTH           = 20,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      address,
    input  logic [31:0]      write_data,
    output logic [31:0]      read_data,
    input  logic [WIDTH-1:0] gpio_in,
    output logic             irq
);

    logic [WIDTH-1:0]     level;
    logic [WIDTH-1:0]     level_d;
    logic [WIDTH-1:0]     irq_en;
    logic [WIDTH-1:0]     rise_en;
    logic [WIDTH-1:0]     fall_en;
    logic [WIDTH-1:0]     pending;
    logic [WIDTH-1:0]     rise;
    logic [WIDTH-1:0]     fall;
    logic [WIDTH-1:0]     w1c;
    logic [WIDTH-1:0]     wdata;
    logic [WIDTH-1:0]     sel;
    logic [REG_IDX_W-1:0] reg_idx;
    logic                 unused_bus_bits;

    assign reg_idx         = address[4:2];
    assign wdata           = write_data[WIDTH-1:0];
    assign unused_bus_bits = ^{address[31:5], address[1:0], write_data[31:WIDTH]};

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .reset(reset),
            .pin  (gpio_in[i]),
            .level(level[i])
        );
    end

    assign rise = level & ~level_d;
    assign fall = ~level & level_d;
    assign w1c  = (write && reg_idx == REG_PENDING) ? wdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            level_d <= '0;
            irq_en  <= '0;
            rise_en <= '0;
            fall_en <= '0;
            pending <= '0;
        end else begin
            level_d <= level;
            if (write && reg_idx == REG_IRQ_EN)  irq_en  <= wdata;
            if (write && reg_idx == REG_RISE_EN) rise_en <= wdata;
            if (write && reg_idx == REG_FALL_EN) fall_en <= wdata;
            // Hardware set is ORed in after the clear so a coincident edge wins.
            pending <= (pending & ~w1c) | (rise & rise_en) | (fall & fall_en);
        end
    end

    always_comb begin
        sel = '0;
        case (reg_idx)
            REG_IRQ_EN:  sel = irq_en;
            REG_RISE_EN: sel = rise_en;
            REG_FALL_EN: sel = fall_en;
            REG_PENDING: sel = pending;
            REG_LEVEL:   sel = level;
            default:     sel = '0;
        endcase
        read_data = read ? 32'(sel) : 32'd0;
    end

    assign irq = |(pending & irq_en);

endmodule

// File: doc/gpio_irq_ctrl.md
Name: gpio_irq_ctrl

Overview:
Memory-mapped interrupt controller sitting directly downstream of the GPIO block; it consumes that block's per-pin input values (gpio_in).
Each pin is synchronised, debounced and edge-detected. Per-pin pending bits are raised on enabled edges and combined into one level-sensitive irq line for the core.
Software reads and clears state over the same read/write/address/write_data/read_data peripheral bus as the other peripherals.

Parameters:
WIDTH, 20, number of GPIO pins monitored (1..31)
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised level must differ from the debounced level before it is accepted (>=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
read  input  1  bus read strobe; read_data is zero when low
write  input  1  bus write strobe, one-cycle pulse per access
address  input  32  byte address; only address[4:2] decoded
write_data  input  32  bus write data
read_data  output  32  combinational read data of selected register
gpio_in  input  WIDTH  raw pin levels from the GPIO block data_out, asynchronous to clk
irq  output  1  OR of (pending & irq_enable), level-sensitive

Behaviour:
- Reset: every register, sync flop, debounce counter, debounced level and pending bit cleared; irq=0; read_data=0.
- Register map, address[4:2], bits above WIDTH-1 read 0:
  - 0 IRQ_EN, R/W
  - 1 RISE_EN, R/W
  - 2 FALL_EN, R/W
  - 3 PENDING, R; write-1-to-clear
  - 4 LEVEL, debounced levels, RO
  - 5..7 unmapped: read 0, writes ignored
- Register writes take effect on the clk edge where write=1.
- read_data = read ? selected register : 0, with no cycle latency.
- Synchroniser: 2 flops per pin (sync1, sync2).
- Debounce, per pin:
  - Counter cnt, width clog2(DEBOUNCE_CYCLES)+1.
  - If sync2==level: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: level<=sync2, cnt<=0.
  - Else: cnt<=cnt+1.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles at sync2 is discarded, and the counter restarts.
- Edge detect: level_d registered copy of level.
  - rise = level & ~level_d
  - fall = ~level & level_d
- Pending update, per bit: pending <= (pending & ~w1c) | (rise & RISE_EN) | (fall & FALL_EN).
  - w1c = write_data bits when write && address[4:2]==3, else 0.
  - A simultaneous hardware set and software clear on the same bit leaves the bit SET.
- IRQ_EN masks only irq, never pending. Enabling a pin with an already-pending bit raises irq the cycle after the IRQ_EN write.
- Latency: pin change settles before clk edge E1; sync2 updates at E2; level updates at E(2+DEBOUNCE_CYCLES); pending sets at E(3+DEBOUNCE_CYCLES); irq is high in the following cycle. Default case = E7.
- Post-reset: level starts at 0. A pin held high through reset produces a rising edge DEBOUNCE_CYCLES+3 edges after reset release. It latches only if RISE_EN is already set, and RISE_EN is 0 after reset, so nothing latches.
- Reset asserted mid-debounce or with pending bits: everything returns to reset values on that edge; no edge is reported from pre-reset state.
- Changing RISE_EN/FALL_EN does not affect already-pending bits.

Decomposition:
- Shared peripheral package holds:
  - Register index constants: REG_IRQ_EN=0, REG_RISE_EN=1, REG_FALL_EN=2, REG_PENDING=3, REG_LEVEL=4.
  - Decoded-field width constant (3).
- One sub-module, gpio_debounce: single-bit synchroniser + counter + level output, parameterised by DEBOUNCE_CYCLES and instantiated WIDTH times. Edge detect, pending and bus logic stay in gpio_irq_ctrl.

Test Plan:
- Reset then read each register with read=1 -> all read 0x00000000, irq=0. read=0 at address 0 -> read_data=0.
- RISE_EN=0x1, IRQ_EN=0x1, gpio_in[0] 0->1 held -> LEVEL=0x1 after edge E6, PENDING=0x1 at E7, irq=1. Write 0x1 to PENDING -> PENDING=0, irq=0 next cycle.
- gpio_in[3] high for 3 cycles only (DEBOUNCE_CYCLES=4) with RISE_EN=0x8 -> LEVEL[3] stays 0, PENDING stays 0.
- FALL_EN=0x20, IRQ_EN=0: pin 5 high then low, both debounced -> PENDING=0x20, irq=0. Then write IRQ_EN=0x20 -> irq=1 next cycle.
- Arrange a rise on pin 2 landing on the same edge as a W1C write of 0x4 -> PENDING[2]=1 afterwards.
- Assert reset while pin 1 is mid-debounce (cnt=2) with PENDING=0x2 -> PENDING=0, LEVEL=0, irq=0. Pin still high after release with RISE_EN=0 after reset -> PENDING remains 0, LEVEL[1]=1 after 6 edges.
